// File: rtl/flash_copy_ctrl_if.sv
// Handshake bundle between the copy engine and the SPI flash reader.
// The engine is the master and the flash reader is the slave.
interface flash_copy_ctrl_if #(
    parameter int FADDR_W = 22
);
    logic               flash_start;
    logic [FADDR_W-1:0] flash_addr;
    logic               flash_busy;
    logic [31:0]        flash_rdata;

    modport master (
        output flash_start,
        output flash_addr,
        input  flash_busy,
        input  flash_rdata
    );

    modport slave (
        input  flash_start,
        input  flash_addr,
        output flash_busy,
        output flash_rdata
    );
endinterface

// File: rtl/flash_copy_ctrl.sv
// Flash-to-blockram copy engine with CPU register interface and RAM write-port arbitration.
// Optional level done/error interrupt is built when FLASH_COPY_IRQ_EN is defined.
module flash_copy_ctrl #(
    parameter int FADDR_W   = 22,
    parameter int LEN_W     = 16,
    parameter int MAX_DEFER = 4,
    parameter int TIMEOUT   = 1023
) (
    input  logic                    clk,
    input  logic                    resetn,
    flash_copy_ctrl_if.master       fl,
    input  logic                    cfg_we,
    input  logic [1:0]              cfg_sel,
    input  logic [31:0]             cfg_wdata,
    output logic [31:0]             cfg_rdata,
    input  logic                    cpu_req,
    output logic                    cpu_stall,
    output logic                    eng_we,
    output logic [31:0]             eng_addr,
    output logic [31:0]             eng_wdata
`ifdef FLASH_COPY_IRQ_EN
    ,
    output logic                    irq
`endif
);
    localparam int DEF_W  = $clog2(MAX_DEFER + 1);
    localparam int TCNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO, WRITE, FIN} state_t;

    state_t             state_reg;
    logic [FADDR_W-1:0] src_reg;
    logic [31:0]        dst_reg;
    logic [LEN_W-1:0]   len_reg;
    logic [FADDR_W-1:0] src_work_reg;
    logic [31:0]        dst_work_reg;
    logic [LEN_W-1:0]   rem_reg;
    logic [31:0]        data_reg;
    logic [DEF_W-1:0]   defer_reg;
    logic [TCNT_W-1:0]  tcnt_reg;
    logic               busy_reg;
    logic               done_reg;
    logic               err_reg;
    logic               abrt_reg;
    logic               abort_pend_reg;

    logic               ctrl_wr;
    logic               start_wr;
    logic               clr_stat;
    logic               defer_full;
    logic               eng_write;
    logic               timed_out;
    logic               err_set;
    logic               done_set;
    logic [15:0]        rem16;

    assign ctrl_wr    = cfg_we && (cfg_sel == 2'd3);
    assign start_wr   = ctrl_wr && cfg_wdata[0];
    assign clr_stat   = ctrl_wr && !cfg_wdata[0];
    assign defer_full = (defer_reg == DEF_W'(MAX_DEFER));
    assign eng_write  = (state_reg == WRITE) && (!cpu_req || defer_full);
    assign timed_out  = (tcnt_reg == TCNT_W'(TIMEOUT));
    assign err_set    = timed_out && (((state_reg == WAIT_HI) && !fl.flash_busy) ||
                                      ((state_reg == WAIT_LO) && fl.flash_busy));
    assign done_set   = (state_reg == FIN) && !abort_pend_reg;
    assign rem16      = 16'(rem_reg);

    // A pending abort suppresses the next read request instead of issuing it.
    assign fl.flash_start = (state_reg == ISSUE) && !abort_pend_reg;
    assign fl.flash_addr  = src_work_reg;
    assign eng_we         = eng_write;
    assign cpu_stall      = (state_reg == WRITE) && cpu_req && defer_full;
    assign eng_addr       = dst_work_reg;
    assign eng_wdata      = data_reg;

    always_comb begin
        cfg_rdata = 32'd0;
        case (cfg_sel)
            2'd0:    cfg_rdata = 32'(src_reg);
            2'd1:    cfg_rdata = dst_reg;
            2'd2:    cfg_rdata = 32'(len_reg);
            default: cfg_rdata = {busy_reg, done_reg, err_reg, abrt_reg, 12'd0, rem16};
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg      <= IDLE;
            src_reg        <= '0;
            dst_reg        <= '0;
            len_reg        <= '0;
            src_work_reg   <= '0;
            dst_work_reg   <= '0;
            rem_reg        <= '0;
            data_reg       <= '0;
            defer_reg      <= '0;
            tcnt_reg       <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
            abrt_reg       <= 1'b0;
            abort_pend_reg <= 1'b0;
        end else begin
            // Register writes first; FSM status updates below take precedence.
            if (cfg_we) begin
                case (cfg_sel)
                    2'd0: if (!busy_reg) src_reg <= {cfg_wdata[FADDR_W-1:2], 2'b00};
                    2'd1: if (!busy_reg) dst_reg <= {cfg_wdata[31:2], 2'b00};
                    2'd2: if (!busy_reg) len_reg <= cfg_wdata[LEN_W-1:0];
                    default: begin
                        if (!cfg_wdata[0]) begin
                            done_reg <= 1'b0;
                            err_reg  <= 1'b0;
                            abrt_reg <= 1'b0;
                        end
                        if (cfg_wdata[1] && busy_reg) abort_pend_reg <= 1'b1;
                    end
                endcase
            end

            case (state_reg)
                IDLE: begin
                    if (start_wr) begin
                        done_reg       <= 1'b0;
                        err_reg        <= 1'b0;
                        abrt_reg       <= 1'b0;
                        abort_pend_reg <= 1'b0;
                        if (len_reg != '0) begin
                            src_work_reg <= src_reg;
                            dst_work_reg <= dst_reg;
                            rem_reg      <= len_reg;
                            busy_reg     <= 1'b1;
                            state_reg    <= ISSUE;
                        end else begin
                            rem_reg   <= '0;
                            state_reg <= FIN;
                        end
                    end
                end
                ISSUE: begin
                    tcnt_reg <= '0;
                    if (abort_pend_reg) begin
                        busy_reg       <= 1'b0;
                        abrt_reg       <= 1'b1;
                        abort_pend_reg <= 1'b0;
                        state_reg      <= IDLE;
                    end else begin
                        state_reg <= WAIT_HI;
                    end
                end
                WAIT_HI, WAIT_LO: begin
                    if ((state_reg == WAIT_HI) && fl.flash_busy) begin
                        tcnt_reg  <= '0;
                        state_reg <= WAIT_LO;
                    end else if ((state_reg == WAIT_LO) && !fl.flash_busy) begin
                        data_reg  <= fl.flash_rdata;
                        state_reg <= WRITE;
                    end else if (err_set) begin
                        err_reg        <= 1'b1;
                        busy_reg       <= 1'b0;
                        abort_pend_reg <= 1'b0;
                        state_reg      <= IDLE;
                    end else begin
                        tcnt_reg <= tcnt_reg + TCNT_W'(1);
                    end
                end
                WRITE: begin
                    if (eng_write) begin
                        defer_reg    <= '0;
                        src_work_reg <= src_work_reg + FADDR_W'(4);
                        dst_work_reg <= dst_work_reg + 32'd4;
                        rem_reg      <= rem_reg - LEN_W'(1);
                        state_reg    <= (rem_reg == LEN_W'(1)) ? FIN : ISSUE;
                    end else begin
                        defer_reg <= defer_reg + DEF_W'(1);
                    end
                end
                FIN: begin
                    busy_reg       <= 1'b0;
                    abort_pend_reg <= 1'b0;
                    if (abort_pend_reg) abrt_reg <= 1'b1;
                    else                done_reg <= 1'b1;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef FLASH_COPY_IRQ_EN
    logic irq_reg;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            irq_reg <= 1'b0;
        end else if (done_set || err_set) begin
            irq_reg <= 1'b1;
        end else if (clr_stat) begin
            irq_reg <= 1'b0;
        end
    end

    assign irq = irq_reg;
`else
    logic unused_status;
    assign unused_status = done_set ^ clr_stat;
`endif
endmodule

// File: tb/tb_flash_copy_ctrl.sv
// Directed bench for flash_copy_ctrl: register table, copy, zero length, deferral,
// abort, timeout, address wrap and mid-transfer reset.
module tb_flash_copy_ctrl;
    localparam int TIMEOUT = 1023;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_sel = 2'd0;
    logic [31:0] cfg_wdata = 32'd0;
    logic [31:0] cfg_rdata;
    logic        cpu_req = 1'b0;
    logic        cpu_stall;
    logic        eng_we;
    logic [31:0] eng_addr;
    logic [31:0] eng_wdata;
`ifdef FLASH_COPY_IRQ_EN
    logic        irq;
`endif

    flash_copy_ctrl_if #(.FADDR_W(22)) fl ();

    flash_copy_ctrl #(.FADDR_W(22), .LEN_W(16), .MAX_DEFER(4), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .fl        (fl),
        .cfg_we    (cfg_we),
        .cfg_sel   (cfg_sel),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .cpu_req   (cpu_req),
        .cpu_stall (cpu_stall),
        .eng_we    (eng_we),
        .eng_addr  (eng_addr),
        .eng_wdata (eng_wdata)
`ifdef FLASH_COPY_IRQ_EN
        ,
        .irq       (irq)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int nchecks = 0;

    // Monitor logs and the flash reader model, all sampled/driven on the falling edge.
    logic [31:0] st_addr [64];
    logic [31:0] wr_addr [64];
    logic [31:0] wr_data [64];
    int          wr_cyc  [64];
    int nstarts = 0, nwrites = 0, stall_cnt = 0, stall_cyc = 0, fall_cyc = 0, cyc = 0;
    int fcnt = 0;
    bit flash_en = 1'b1;

    function automatic logic [31:0] pat(input logic [31:0] a);
        return 32'hC0DE0000 ^ (a * 32'd3);
    endfunction

    initial begin
        fl.flash_busy  = 1'b0;
        fl.flash_rdata = 32'd0;
    end

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!resetn) begin
            fcnt = 0;
            fl.flash_busy = 1'b0;
        end else begin
            if (fl.flash_start && nstarts < 64) begin
                st_addr[nstarts] = 32'(fl.flash_addr);
                nstarts = nstarts + 1;
            end
            if (eng_we && nwrites < 64) begin
                wr_addr[nwrites] = eng_addr;
                wr_data[nwrites] = eng_wdata;
                wr_cyc[nwrites]  = cyc;
                nwrites = nwrites + 1;
            end
            if (cpu_stall) begin
                stall_cnt = stall_cnt + 1;
                stall_cyc = cyc;
            end
            if (fcnt != 0) begin
                fcnt = fcnt - 1;
                if (fcnt == 0) begin
                    fl.flash_busy = 1'b0;
                    fall_cyc = cyc;
                end
            end else if (fl.flash_start && flash_en) begin
                fl.flash_busy  = 1'b1;
                fl.flash_rdata = pat(32'(fl.flash_addr));
                fcnt = 8;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    task automatic cfg_write(input logic [1:0] sel, input logic [31:0] data);
        cfg_we = 1'b1;
        cfg_sel = sel;
        cfg_wdata = data;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic read_reg(input logic [1:0] sel, output logic [31:0] data);
        cfg_sel = sel;
        #1;
        data = cfg_rdata;
    endtask

    task automatic wait_idle(input int budget, output int n);
        logic [31:0] st;
        n = 0;
        read_reg(2'd3, st);
        while (st[31] && n < budget) begin
            @(posedge clk);
            #1;
            n++;
            read_reg(2'd3, st);
        end
        check("busy_clears_in_budget", {31'd0, st[31]}, 32'd0);
    endtask

    task automatic wait_starts(input int target, input int budget);
        int n = 0;
        while (nstarts < target && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("flash_start_seen_in_budget", 32'(nstarts >= target), 32'd1);
    endtask

    task automatic setup(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l);
        cfg_write(2'd0, s);
        cfg_write(2'd1, d);
        cfg_write(2'd2, l);
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  sel;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [8];

    initial begin
        logic [31:0] rd;
        int bs, bw, bst, n;

        vecs[0] = '{1'b1, 2'd0, 32'h0000_0103, 32'h0000_0100};
        vecs[1] = '{1'b1, 2'd0, 32'hFFFF_FFFF, 32'h003F_FFFC};
        vecs[2] = '{1'b1, 2'd1, 32'h1234_5677, 32'h1234_5674};
        vecs[3] = '{1'b1, 2'd2, 32'hABCD_0007, 32'h0000_0007};
        vecs[4] = '{1'b0, 2'd3, 32'h0000_0000, 32'h0000_0000};
        vecs[5] = '{1'b1, 2'd3, 32'h0000_0000, 32'h0000_0000};
        vecs[6] = '{1'b1, 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFC};
        vecs[7] = '{1'b1, 2'd2, 32'h0000_0000, 32'h0000_0000};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {28'd0, fl.flash_start, eng_we, cpu_stall, 1'b0}, 32'd0);
        check("reset_flash_addr", 32'(fl.flash_addr), 32'd0);
        check("reset_eng_addr", eng_addr, 32'd0);
        read_reg(2'd3, rd);
        check("reset_stat", rd, 32'd0);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Register table
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].we) cfg_write(vecs[i].sel, vecs[i].wdata);
            read_reg(vecs[i].sel, rd);
            check($sformatf("reg_vec%0d_sel%0d", i, vecs[i].sel), rd, vecs[i].exp);
        end

        // Basic three-word copy
        setup(32'h100, 32'h40, 32'd3);
        bs = nstarts; bw = nwrites; bst = stall_cnt;
        cfg_write(2'd3, 32'd1);
        cfg_write(2'd0, 32'h900);
        read_reg(2'd0, rd);
        check("src_write_ignored_busy", rd, 32'h100);
        wait_idle(500, n);
        check("copy_nstarts", 32'(nstarts - bs), 32'd3);
        check("copy_start_addr0", st_addr[bs], 32'h100);
        check("copy_start_addr1", st_addr[bs+1], 32'h104);
        check("copy_start_addr2", st_addr[bs+2], 32'h108);
        check("copy_nwrites", 32'(nwrites - bw), 32'd3);
        check("copy_wr_addr0", wr_addr[bw], 32'h40);
        check("copy_wr_addr1", wr_addr[bw+1], 32'h44);
        check("copy_wr_addr2", wr_addr[bw+2], 32'h48);
        check("copy_wr_data0", wr_data[bw], pat(32'h100));
        check("copy_wr_data2", wr_data[bw+2], pat(32'h108));
        check("copy_write_latency", 32'(wr_cyc[bw+2] - fall_cyc), 32'd1);
        check("copy_no_stall", 32'(stall_cnt - bst), 32'd0);
        read_reg(2'd3, rd);
        check("copy_stat", rd, 32'h4000_0000);

        // Zero length
        cfg_write(2'd2, 32'd0);
        bs = nstarts;
        cfg_write(2'd3, 32'd1);
        read_reg(2'd3, rd);
        check("len0_stat_after_1", rd, 32'h0000_0000);
        @(posedge clk);
        #1;
        read_reg(2'd3, rd);
        check("len0_stat_after_2", rd, 32'h4000_0000);
        repeat (5) @(posedge clk);
        #1;
        check("len0_no_flash", 32'(nstarts - bs), 32'd0);

        // CPU holds the RAM port through WRITE
        setup(32'h300, 32'h500, 32'd1);
        bw = nwrites; bst = stall_cnt;
        cpu_req = 1'b1;
        cfg_write(2'd3, 32'd1);
        wait_idle(500, n);
        cpu_req = 1'b0;
        check("defer_nwrites", 32'(nwrites - bw), 32'd1);
        check("defer_write_cycle", 32'(wr_cyc[bw] - fall_cyc), 32'd5);
        check("defer_stall_count", 32'(stall_cnt - bst), 32'd1);
        check("defer_stall_with_write", 32'(stall_cyc), 32'(wr_cyc[bw]));

        // Abort during the second word
        setup(32'h200, 32'h80, 32'd5);
        bs = nstarts; bw = nwrites;
        cfg_write(2'd3, 32'd1);
        wait_starts(bs + 2, 200);
        cfg_write(2'd3, 32'd2);
        wait_idle(500, n);
        check("abort_nwrites", 32'(nwrites - bw), 32'd2);
        check("abort_nstarts", 32'(nstarts - bs), 32'd2);
        check("abort_wr_addr1", wr_addr[bw+1], 32'h84);
        read_reg(2'd3, rd);
        check("abort_stat", rd, 32'h1000_0003);

        // Flash never responds
        flash_en = 1'b0;
        setup(32'h400, 32'h600, 32'd1);
        bw = nwrites;
        cfg_write(2'd3, 32'd1);
        wait_idle(2000, n);
        flash_en = 1'b1;
        check("timeout_edges", 32'(n), 32'(TIMEOUT + 2));
        read_reg(2'd3, rd);
        check("timeout_stat", rd, 32'h2000_0001);
        check("timeout_no_write", 32'(nwrites - bw), 32'd0);
        cfg_write(2'd3, 32'd0);
        read_reg(2'd3, rd);
        check("stat_clear", rd, 32'h0000_0001);

        // Source and destination wrap
        setup(32'h3F_FFFC, 32'hFFFF_FFFC, 32'd2);
        bs = nstarts; bw = nwrites;
        cfg_write(2'd3, 32'd1);
        wait_idle(500, n);
        check("wrap_src_addr0", st_addr[bs], 32'h3F_FFFC);
        check("wrap_src_addr1", st_addr[bs+1], 32'h0);
        check("wrap_dst_addr1", wr_addr[bw+1], 32'h0);
        check("wrap_wr_data1", wr_data[bw+1], pat(32'h0));

        // Reset in the middle of a transfer
        setup(32'h700, 32'h800, 32'd3);
        bs = nstarts;
        cfg_write(2'd3, 32'd1);
        wait_starts(bs + 1, 200);
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        check("midrst_outputs", {28'd0, fl.flash_start, eng_we, cpu_stall, 1'b0}, 32'd0);
        check("midrst_flash_addr", 32'(fl.flash_addr), 32'd0);
        check("midrst_eng_addr", eng_addr, 32'd0);
        check("midrst_eng_wdata", eng_wdata, 32'd0);
        read_reg(2'd3, rd);
        check("midrst_stat", rd, 32'd0);
        read_reg(2'd1, rd);
        check("midrst_dst", rd, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        #1;
        setup(32'h10, 32'h20, 32'd2);
        bs = nstarts; bw = nwrites;
        cfg_write(2'd3, 32'd1);
        wait_idle(500, n);
        check("post_rst_nwrites", 32'(nwrites - bw), 32'd2);
        check("post_rst_wr_addr1", wr_addr[bw+1], 32'h24);
        check("post_rst_wr_data1", wr_data[bw+1], pat(32'h14));
        read_reg(2'd3, rd);
        check("post_rst_stat", rd, 32'h4000_0000);

        $display("Result: errors=%0d of %0d checks", errors, nchecks);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
